// File: rtl/imem_loader.sv
// imem_loader: instruction-memory writer. Assembles a little-endian byte stream
// (4-byte length N, then N 4-byte words) into 32-bit words and writes them to the
// instruction memory at BASE_ADDR, +4, +8, ... The core is held in reset until
// the image has been fully written.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a one-byte XOR trailer that
// must match the XOR of all length and data bytes.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic        core_rst_n
);

  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] len_q, len_d;
  logic [15:0] words_q, words_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic        last_byte;
  logic [31:0] asm_word;
  logic [15:0] words_inc;

  // Status outputs decode directly from the registered state.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_rst_n = 1'b0;
    unique case (state_q)
      StLen, StData, StChk: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
      end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;

  // Incoming byte shifts in at the top, so the first byte lands in bits 7:0.
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_idx_q == 2'd3);
  assign asm_word  = {in_data, shift_q[31:8]};
  assign words_inc = words_q + 16'd1;

  // Next-state logic: byte assembly, length decode and word write.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    len_d      = len_q;
    words_d    = words_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (accept && (state_q != StChk)) begin
      csum_d = csum_q ^ in_data;
    end
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLen;
          byte_idx_d = 2'd0;
          words_d    = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      StLen: begin
        if (accept) begin
          shift_d    = asm_word;
          byte_idx_d = byte_idx_q + 2'd1;
          if (last_byte) begin
            len_d = asm_word;
            if (asm_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StDone;
`endif
            end else if (asm_word > MaxWords) begin
              state_d = StError;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (accept) begin
          shift_d    = asm_word;
          byte_idx_d = byte_idx_q + 2'd1;
          if (last_byte) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
            wdata_d = asm_word;
            words_d = words_inc;
            if ({16'd0, words_inc} == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StDone;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_idx_q <= 2'd0;
      shift_q    <= 32'd0;
      len_q      <= 32'd0;
      words_q    <= 16'd0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      words_q    <= words_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Inputs change 1ns after the rising edge;
// outputs are sampled at that same point.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic        core_rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_done[$];

  imem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded),
    .core_rst_n  (core_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write pulse together with the done/core_rst_n level in that cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_done.push_back(done && core_rst_n);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_bad++;
      $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  logic [31:0] img [4];

  initial begin
    img[0] = 32'hFFC4_A303;
    img[1] = 32'h0000_0013;
    img[2] = 32'h1234_5678;
    img[3] = 32'hDEAD_BEEF;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();

    // Reset values.
    chk("rst_flags", {26'd0, in_ready, imem_we, busy, done, error, core_rst_n}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Valid in idle is ignored.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    tick();
    in_valid = 1'b0;
    chk("idle_ignore", {29'd0, in_ready, busy, done}, 32'd0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Four words back-to-back; first word bytes 03 A3 C4 FF.
    clear_log();
    pulse_start();
    chk("len_flags", {28'd0, in_ready, busy, done, core_rst_n}, 32'b1100);
    send_word(32'd4, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hC4, 1'b0);
    send_byte(8'hFF, 1'b0);
    chk("w0_pulse", {30'd0, imem_we, in_ready}, 32'b11);
    chk("w0_addr", imem_addr, 32'h0);
    chk("w0_data", imem_wdata, 32'hFFC4_A303);
    chk("w0_count", {16'd0, words_loaded}, 32'd1);
    for (int i = 1; i < 4; i++) send_word(img[i], 1'b0);
    chk("t1_final", {27'd0, imem_we, done, core_rst_n, busy, in_ready}, 32'b11100);
    chk("t1_words", {16'd0, words_loaded}, 32'd4);
    chk("t1_addr3", imem_addr, 32'd12);
    tick();
    chk("t1_we_low", {31'd0, imem_we}, 32'd0);
    chk("t1_nwr", wr_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wr_addr", wr_addr[i], 32'(4 * i));
      chk("t1_wr_data", wr_data[i], img[i]);
      chk("t1_wr_done", {31'd0, wr_done[i]}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Same image with in_valid toggled every other cycle.
    clear_log();
    pulse_start();
    chk("t2_restart", {29'd0, core_rst_n, done, busy}, 32'b001);
    chk("t2_words0", {16'd0, words_loaded}, 32'd0);
    send_word(32'd4, 1'b1);
    for (int i = 0; i < 4; i++) send_word(img[i], 1'b1);
    chk("t2_final", {29'd0, imem_we, done, core_rst_n}, 32'b111);
    tick();
    chk("t2_nwr", wr_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_wr_addr", wr_addr[i], 32'(4 * i));
      chk("t2_wr_data", wr_data[i], img[i]);
    end

    // Zero length: done one cycle after the 4th length byte, no writes.
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t3_pre_done", {31'd0, done}, 32'd0);
    send_byte(8'h00, 1'b0);
    chk("t3_done", {29'd0, imem_we, done, core_rst_n}, 32'b011);
    tick();
    chk("t3_nwr", wr_addr.size(), 32'd0);

    // Length 257 is rejected.
    clear_log();
    pulse_start();
    send_word(32'h0000_0101, 1'b0);
    chk("t4_err", {27'd0, error, core_rst_n, in_ready, busy, done}, 32'b10000);
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    in_valid = 1'b0;
    chk("t4_hold", {30'd0, error, in_ready}, 32'b10);
    chk("t4_nwr", wr_addr.size(), 32'd0);

    // Upper length bits are not ignored.
    pulse_start();
    chk("t4b_cleared", {31'd0, error}, 32'd0);
    send_word(32'h0001_0000, 1'b0);
    chk("t4b_err", {31'd0, error}, 32'd1);

    // Recovery, with a start pulse mid-length that must be ignored.
    clear_log();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    chk("t4_recover", {29'd0, done, error, core_rst_n}, 32'b101);
    tick();
    chk("t4_nwr", wr_addr.size(), 32'd1);
    chk("t4_data", wr_data[0], 32'hCAFE_F00D);

    // Reset mid-session after 2 of 3 words, then reload.
    clear_log();
    pulse_start();
    send_word(32'd3, 1'b0);
    send_word(img[2], 1'b0);
    send_word(img[3], 1'b0);
    chk("t5_two", {16'd0, words_loaded}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_flags", {26'd0, in_ready, imem_we, busy, done, error, core_rst_n}, 32'd0);
    chk("t5_async_words", {16'd0, words_loaded}, 32'd0);
    chk("t5_async_addr", imem_addr, 32'h0);
    chk("t5_async_wdata", imem_wdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(img[1], 1'b0);
    chk("t5_reload", {30'd0, done, core_rst_n}, 32'b11);
    tick();
    chk("t5_nwr", wr_addr.size(), 32'd1);
    chk("t5_addr", wr_addr[0], 32'h0);
    chk("t5_data", wr_data[0], img[1]);
`else
    // Checksum: 01 00 00 00, 13 00 00 00, trailer 12.
    clear_log();
    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    chk("c1_pulse", {30'd0, imem_we, done}, 32'b10);
    send_byte(8'h12, 1'b0);
    chk("c1_done", {29'd0, done, error, core_rst_n}, 32'b101);
    tick();
    chk("c1_nwr", wr_addr.size(), 32'd1);
    chk("c1_data", wr_data[0], 32'h0000_0013);

    pulse_start();
    send_word(32'd1, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("c2_err", {29'd0, done, error, core_rst_n}, 32'b010);

    // Zero length: trailer is XOR of length bytes (0).
    pulse_start();
    send_word(32'd0, 1'b0);
    chk("c3_wait", {30'd0, done, busy}, 32'b01);
    send_byte(8'h00, 1'b0);
    chk("c3_done", {31'd0, done}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
